// File: rtl/nibble_tx.sv
// -----------------------------------------------------------------------------
// nibble_tx
//   Transmit side of the nibble-split port interface. Bytes arrive on an 8-bit
//   valid/ready input, are buffered in a small FIFO, and leave as two 4-bit
//   nibbles on a narrow valid/ready output. Every byte yields exactly two
//   nibble beats. With out_ready held high a continuous stream has no gaps.
//
//   Parameters
//     DEPTH      byte FIFO depth (power of 2, >= 2)
//     MSN_FIRST  1: bits [7:4] go out first, 0: bits [3:0] go out first
//
//   Ports
//     clk        single clock, rising edge
//     rst_n      asynchronous active-low reset
//     in_data    byte to transmit (raw bits, no sign handling)
//     in_valid   in_data valid
//     in_ready   FIFO can accept a byte (level != DEPTH)
//     out_nib    current nibble (registered)
//     out_valid  out_nib valid (registered)
//     out_ready  downstream accepts the nibble
//     out_last   out_nib is the second nibble of its byte (registered)
//     level      bytes held in the FIFO, not counting the byte being sent
//     out_par    even parity of out_nib, registered with it
//                (present only when NIBBLE_TX_PARITY_EN is defined)
//
//   Build option
//     NIBBLE_TX_PARITY_EN  adds the out_par output
// -----------------------------------------------------------------------------
module nibble_tx #(
    parameter int DEPTH     = 4,
    parameter bit MSN_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [3:0]               out_nib,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic [$clog2(DEPTH):0]   level
`ifdef NIBBLE_TX_PARITY_EN
    ,
    output logic                     out_par
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2
    } state_e;

    function automatic logic [3:0] first_nib(input logic [7:0] b);
        return MSN_FIRST ? b[7:4] : b[3:0];
    endfunction

    function automatic logic [3:0] second_nib(input logic [7:0] b);
        return MSN_FIRST ? b[3:0] : b[7:4];
    endfunction

    // Pointers carry one extra MSB so that full (level == DEPTH) and empty
    // (level == 0) stay distinguishable after wrap.
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]  level_w;
    logic [7:0]   mem_q [DEPTH];
    logic [7:0]   head;

    state_e       state_q;
    logic [7:0]   hold_q;
    logic         out_valid_q;
    logic [3:0]   out_nib_q;
    logic         out_last_q;
    logic         out_par_q;

    logic         push;
    logic         pop;

    assign level_w  = wr_ptr_q - rd_ptr_q;
    assign level    = level_w;
    // in_ready looks only at the registered level, so a full FIFO never
    // accepts a byte even in a cycle where it is also popped.
    assign in_ready = (level_w != FULL_LVL);
    assign push     = in_valid && in_ready;
    assign head     = mem_q[rd_ptr_q[AW-1:0]];

    // A pop loads the holding register: from IDLE whenever data is queued,
    // and from SECOND when its last nibble is accepted (back-to-back bytes).
    assign pop = (level_w != '0) &&
                 ((state_q == IDLE) || ((state_q == SECOND) && out_ready));

    assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};

    // FIFO storage holds no control state, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Output sequencer: every output is a register updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_q      <= 8'h00;
            out_valid_q <= 1'b0;
            out_nib_q   <= 4'h0;
            out_last_q  <= 1'b0;
            out_par_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        hold_q      <= head;
                        out_valid_q <= 1'b1;
                        out_nib_q   <= first_nib(head);
                        out_last_q  <= 1'b0;
                        out_par_q   <= ^first_nib(head);
                        state_q     <= FIRST;
                    end
                end
                FIRST: begin
                    if (out_ready) begin
                        out_nib_q  <= second_nib(hold_q);
                        out_last_q <= 1'b1;
                        out_par_q  <= ^second_nib(hold_q);
                        state_q    <= SECOND;
                    end
                end
                SECOND: begin
                    if (out_ready) begin
                        if (pop) begin
                            hold_q      <= head;
                            out_nib_q   <= first_nib(head);
                            out_last_q  <= 1'b0;
                            out_par_q   <= ^first_nib(head);
                            state_q     <= FIRST;
                        end else begin
                            out_valid_q <= 1'b0;
                            out_nib_q   <= 4'h0;
                            out_last_q  <= 1'b0;
                            out_par_q   <= 1'b0;
                            state_q     <= IDLE;
                        end
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_nib   = out_nib_q;
    assign out_last  = out_last_q;

`ifdef NIBBLE_TX_PARITY_EN
    assign out_par = out_par_q;
`else
    // Parity is still tracked so the register set is identical in both
    // builds; without the port it simply has no load.
    logic unused_par;
    assign unused_par = out_par_q;
`endif

endmodule

// File: tb/tb_nibble_tx.sv
module tb_nibble_tx;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       out_ready;

    // DUT with MSN_FIRST = 1
    logic       rdy1, vld1, last1;
    logic [3:0] nib1;
    logic [2:0] lvl1;
    // DUT with MSN_FIRST = 0
    logic       rdy0, vld0, last0;
    logic [3:0] nib0;
    logic [2:0] lvl0;
`ifdef NIBBLE_TX_PARITY_EN
    logic       par1, par0;
`endif

    int checks = 0;
    int errors = 0;

    // Expected beats: {parity, last, nibble}
    logic [5:0] q1[$];
    logic [5:0] q0[$];

    nibble_tx #(.DEPTH(4), .MSN_FIRST(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy1), .out_nib(nib1), .out_valid(vld1), .out_ready(out_ready),
        .out_last(last1), .level(lvl1)
`ifdef NIBBLE_TX_PARITY_EN
        , .out_par(par1)
`endif
    );

    nibble_tx #(.DEPTH(4), .MSN_FIRST(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy0), .out_nib(nib0), .out_valid(vld0), .out_ready(out_ready),
        .out_last(last0), .level(lvl0)
`ifdef NIBBLE_TX_PARITY_EN
        , .out_par(par0)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [5:0] beat(input logic [3:0] n, input logic l);
        return {^n, l, n};
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push(input logic [7:0] b);
        logic acc;
        int   n;
        in_data  = b;
        in_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = rdy1;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            check("push_timeout", 32'(n), 32'd0);
        end else begin
            q1.push_back(beat(b[7:4], 1'b0));
            q1.push_back(beat(b[3:0], 1'b1));
            q0.push_back(beat(b[3:0], 1'b0));
            q0.push_back(beat(b[7:4], 1'b1));
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard and stall-hold monitors, sampling at the falling edge.
    initial begin : mon1
        logic [5:0] e;
        logic       st_prev;
        logic [3:0] pn;
        logic       pl;
        st_prev = 1'b0;
        pn = 4'h0;
        pl = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                st_prev = 1'b0;
            end else begin
                if (st_prev) begin
                    check("stall1_nib", 32'(nib1), 32'(pn));
                    check("stall1_last", 32'(last1), 32'(pl));
                end
                if (vld1 && out_ready) begin
                    if (q1.size() == 0) begin
                        check("sb1_unexpected_beat", 32'(nib1), 32'hFFFF);
                    end else begin
                        e = q1.pop_front();
`ifdef NIBBLE_TX_PARITY_EN
                        check("sb1_beat", 32'({par1, last1, nib1}), 32'(e));
`else
                        check("sb1_beat", 32'({last1, nib1}), 32'(e[4:0]));
`endif
                    end
                end
                st_prev = vld1 && !out_ready;
                pn = nib1;
                pl = last1;
            end
        end
    end

    initial begin : mon0
        logic [5:0] e;
        logic       st_prev;
        logic [3:0] pn;
        st_prev = 1'b0;
        pn = 4'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                st_prev = 1'b0;
            end else begin
                if (st_prev) check("stall0_nib", 32'(nib0), 32'(pn));
                if (vld0 && out_ready) begin
                    if (q0.size() == 0) begin
                        check("sb0_unexpected_beat", 32'(nib0), 32'hFFFF);
                    end else begin
                        e = q0.pop_front();
`ifdef NIBBLE_TX_PARITY_EN
                        check("sb0_beat", 32'({par0, last0, nib0}), 32'(e));
`else
                        check("sb0_beat", 32'({last0, nib0}), 32'(e[4:0]));
`endif
                    end
                end
                st_prev = vld0 && !out_ready;
                pn = nib0;
            end
        end
    end

    initial begin : stim
        int gaps;
        int busy;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b0;

        // Reset state
        #12;
        check("rst_out_valid", 32'(vld1), 32'd0);
        check("rst_out_nib", 32'(nib1), 32'd0);
        check("rst_out_last", 32'(last1), 32'd0);
        check("rst_level", 32'(lvl1), 32'd0);
`ifdef NIBBLE_TX_PARITY_EN
        check("rst_out_par", 32'(par1), 32'd0);
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;
        cycles(1);
        check("rst_in_ready", 32'(rdy1), 32'd1);

        // 1/2: single byte, both nibble orders, latency
        push(8'hA5);
        check("t1_idle_after_push", 32'(vld1), 32'd0);
        check("t1_level_after_push", 32'(lvl1), 32'd1);
        cycles(1);
        check("t1_first", 32'({vld1, last1, nib1}), 32'({1'b1, 1'b0, 4'hA}));
        check("t2_first", 32'({vld0, last0, nib0}), 32'({1'b1, 1'b0, 4'h5}));
        cycles(1);
        check("t1_second", 32'({vld1, last1, nib1}), 32'({1'b1, 1'b1, 4'h5}));
        check("t2_second", 32'({vld0, last0, nib0}), 32'({1'b1, 1'b1, 4'hA}));
        cycles(1);
        check("t1_done_valid", 32'(vld1), 32'd0);

        // 3: fill while stalled, then drain with no gaps
        out_ready = 1'b0;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        push(8'h55);
        check("t3_level_full", 32'(lvl1), 32'd4);
        check("t3_in_ready_full", 32'(rdy1), 32'd0);
        check("t3_head_nib", 32'({vld1, nib1}), 32'({1'b1, 4'h1}));
        fork
            push(8'h66);
            begin
                cycles(2);
                check("t3_pending_level", 32'(lvl1), 32'd4);
                check("t3_pending_ready", 32'(rdy1), 32'd0);
                out_ready = 1'b1;
                gaps = 0;
                repeat (12) begin
                    @(negedge clk);
                    if (!vld1) gaps++;
                end
                check("t3_no_gaps", 32'(gaps), 32'd0);
            end
        join
        cycles(2);
        check("t3_in_ready_back", 32'(rdy1), 32'd1);
        check("t3_level_empty", 32'(lvl1), 32'd0);
        check("t3_idle", 32'(vld1), 32'd0);

        // 4: toggling out_ready during 8'h3C
        out_ready = 1'b0;
        push(8'h3C);
        cycles(3);
        check("t4_stall_nib", 32'({vld1, last1, nib1}), 32'({1'b1, 1'b0, 4'h3}));
        for (int i = 0; i < 8; i++) begin
            out_ready = i[0];
            cycles(1);
        end
        out_ready = 1'b1;
        cycles(4);
        check("t4_done", 32'(vld1), 32'd0);

        // 5: reset while in SECOND with 3 bytes queued
        out_ready = 1'b0;
        push(8'h51);
        push(8'h52);
        push(8'h53);
        push(8'h54);
        out_ready = 1'b1;
        cycles(1);
        out_ready = 1'b0;
        check("t5_in_second", 32'({vld1, last1, nib1}), 32'({1'b1, 1'b1, 4'h1}));
        check("t5_level_3", 32'(lvl1), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_valid", 32'(vld1), 32'd0);
        check("t5_async_level", 32'(lvl1), 32'd0);
        check("t5_async_valid0", 32'(vld0), 32'd0);
        q1.delete();
        q0.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        busy = 0;
        repeat (10) begin
            @(negedge clk);
            if (vld1 || vld0) busy++;
        end
        check("t5_silent_after_reset", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        push(8'h96);
        cycles(4);

`ifdef NIBBLE_TX_PARITY_EN
        // 6: parity
        push(8'h7E);
        cycles(1);
        check("t6_par_7", 32'({par1, nib1}), 32'({1'b1, 4'h7}));
        cycles(1);
        check("t6_par_E", 32'({par1, nib1}), 32'({1'b1, 4'hE}));
        cycles(1);
        push(8'h30);
        cycles(1);
        check("t6_par_3", 32'({par1, nib1}), 32'({1'b0, 4'h3}));
        cycles(1);
        check("t6_par_0", 32'({par1, nib1}), 32'({1'b0, 4'h0}));
        cycles(2);
`endif

        // Drain and confirm every expected beat was seen
        busy = 0;
        while ((q1.size() != 0 || q0.size() != 0) && busy < 100) begin
            cycles(1);
            busy++;
        end
        check("q1_empty", 32'(q1.size()), 32'd0);
        check("q0_empty", 32'(q0.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
